// File: rtl/trans_divider.sv
// Radix-2 restoring divider with valid/ready result handshake; one quotient bit per BUSY cycle.
// Define TRANS_DIVIDER_FRAC_EN to also produce FW truncated fractional quotient bits.
module trans_divider #(
    parameter int DW = 18,
    parameter int FW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    input  logic          in_valid,
    output logic          rfd,
    output logic [DW-1:0] quotient,
    output logic [FW-1:0] fractional,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          div_by_zero
);

`ifdef TRANS_DIVIDER_FRAC_EN
    localparam int N = DW + FW;
`else
    localparam int N = DW;
`endif
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_last;
    logic            w_zero;

    logic [DW-1:0]   r_dvd;
    logic [DW-1:0]   r_dsr;
    logic [DW:0]     r_rem;
    logic [N-1:0]    r_quo;
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;

    logic [DW:0]     w_trial;
    logic [DW+1:0]   w_diff;
    logic            w_ge;

    assign w_zero = (divisor == '0);
    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next    = r_state;
        w_accept  = 1'b0;
        rfd       = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                rfd = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Once the dividend bits are exhausted the left shift feeds zeros, giving the fractional steps.
    assign w_trial = {r_rem[DW-1:0], r_dvd[DW-1]};
    assign w_diff  = {1'b0, w_trial} - {2'b00, r_dsr};
    assign w_ge    = r_rem[DW] | ~w_diff[DW+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_dsr <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= dividend;
            r_dsr <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
            r_quo <= w_zero ? '1 : '0;
            r_dbz <= w_zero;
        end else if (r_state == S_BUSY) begin
            // NOTE: state registers update with non-blocking assignments so every step sees the pre-edge values.
            r_dvd <= r_dvd << 1;
            r_rem <= w_ge ? w_diff[DW:0] : w_trial;
            r_quo <= {r_quo[N-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign quotient    = r_quo[N-1 -: DW];
    assign div_by_zero = r_dbz;
`ifdef TRANS_DIVIDER_FRAC_EN
    assign fractional  = r_quo[FW-1:0];
`else
    assign fractional  = '0;
`endif

endmodule
